i2c_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that lets NUM_REQ independent requesters share one single-byte I2C master. It sits between client logic and the master's command port. It picks one pending request, issues a single start pulse with the winner's address, direction and write byte, and tracks the master's busy, read-valid and address-error outputs to completion. It reports done, error and read data back to the owning requester, and includes a watchdog against a hung bus.

---
 rtl/i2c_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_i2c_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin arbiter and transaction sequencer that shares one
// single-byte I2C master between NUM_REQ requesters. A winner's address,
// direction and write byte are latched and issued with a one-cycle start
// pulse; the master's busy / read-valid / address-NACK outputs are tracked
// to completion, and a watchdog forces an error if the bus hangs.
module i2c_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     err,
  output logic [7:0]             rdata,
  output logic                   m_start,
  output logic [6:0]             m_addr,
  output logic                   m_rw,
  output logic [7:0]             m_data_w,
  input  logic                   m_busy,
  input  logic [7:0]             m_data_out,
  input  logic                   m_valid_out,
  input  logic                   m_erro_addr
);

  localparam int AW   = 7;
  localparam int DW   = 8;
  localparam int IDXW = $clog2(NUM_REQ);
  localparam int WDW  = $clog2(TIMEOUT_CYC);
  localparam logic [WDW-1:0]  WD_LAST  = WDW'(TIMEOUT_CYC - 1);
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_REPORT    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDXW-1:0]   r_last;
  logic [IDXW-1:0]   r_owner;
  logic [WDW-1:0]    r_wdog;
  logic              r_nack;
  logic              r_rd_ok;
  logic [7:0]        r_hold;

  logic              w_win_found;
  logic [IDXW-1:0]   w_win_idx;
  logic [IDXW-1:0]   w_cand_idx;
  int                w_cand;
  logic              w_in_wait;
  logic              w_tmo;
  logic              w_nack_nxt;
  logic              w_rd_ok_nxt;
  logic [7:0]        w_hold_nxt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [NUM_REQ-1:0] w_done_nxt;
  logic [NUM_REQ-1:0] w_err_nxt;
  logic              w_start_nxt;
  logic [7:0]        w_rdata_nxt;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = 0;
    w_cand_idx  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = int'(r_last) + i;
      if (w_cand >= NUM_REQ) begin
        w_cand = w_cand - NUM_REQ;
      end else begin
        w_cand = w_cand;
      end
      w_cand_idx = IDXW'(w_cand);
      if (!w_win_found && req[w_cand_idx]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand_idx;
      end else begin
        w_win_found = w_win_found;
      end
    end
  end

  // Watchdog expiry and completion flags as they will stand after this cycle.
  always_comb begin
    w_in_wait   = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
    w_tmo       = w_in_wait && (r_wdog == WD_LAST);
    w_nack_nxt  = r_nack | (w_in_wait & m_erro_addr);
    w_rd_ok_nxt = r_rd_ok | ((r_state == S_WAIT_DONE) & m_valid_out);
    if ((r_state == S_WAIT_DONE) && m_valid_out) begin
      w_hold_nxt = m_data_out;
    end else begin
      w_hold_nxt = r_hold;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a busy master blocks new grants from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_win_found && !m_busy) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (w_tmo) begin
          w_state_nxt = S_REPORT;
        end else if (m_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else begin
          w_state_nxt = S_WAIT_BUSY;
        end
      end
      S_WAIT_DONE: begin
        if (w_tmo || !m_busy) begin
          w_state_nxt = S_REPORT;
        end else begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_REPORT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output next-values: pulses line up with the ISSUE and REPORT cycles.
  always_comb begin
    w_gnt_nxt   = '0;
    w_start_nxt = 1'b0;
    w_done_nxt  = '0;
    w_err_nxt   = '0;
    w_rdata_nxt = rdata;
    if (w_state_nxt == S_ISSUE) begin
      w_gnt_nxt[w_win_idx] = 1'b1;
      w_start_nxt          = 1'b1;
    end else begin
      w_start_nxt = 1'b0;
    end
    if (w_state_nxt == S_REPORT) begin
      w_done_nxt[r_owner] = 1'b1;
      w_err_nxt[r_owner]  = w_nack_nxt | w_tmo;
      if (m_rw && w_rd_ok_nxt && !w_nack_nxt && !w_tmo) begin
        w_rdata_nxt = w_hold_nxt;
      end else begin
        w_rdata_nxt = rdata;
      end
    end else begin
      w_err_nxt = '0;
    end
  end

  // Registered outputs, latched command, flags, watchdog and priority pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= '0;
      done     <= '0;
      err      <= '0;
      m_start  <= 1'b0;
      rdata    <= 8'h00;
      m_addr   <= 7'h00;
      m_rw     <= 1'b0;
      m_data_w <= 8'h00;
      r_owner  <= '0;
      r_last   <= LAST_RST;
      r_wdog   <= '0;
      r_nack   <= 1'b0;
      r_rd_ok  <= 1'b0;
      r_hold   <= 8'h00;
    end else begin
      gnt     <= w_gnt_nxt;
      done    <= w_done_nxt;
      err     <= w_err_nxt;
      m_start <= w_start_nxt;
      rdata   <= w_rdata_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_state_nxt == S_ISSUE) begin
            r_owner  <= w_win_idx;
            m_addr   <= req_addr[int'(w_win_idx)*AW +: AW];
            m_rw     <= req_rw[w_win_idx];
            m_data_w <= req_wdata[int'(w_win_idx)*DW +: DW];
          end
        end
        S_ISSUE: begin
          r_wdog <= '0;
        end
        S_WAIT_BUSY, S_WAIT_DONE: begin
          r_wdog  <= r_wdog + WDW'(1);
          r_nack  <= w_nack_nxt;
          r_rd_ok <= w_rd_ok_nxt;
          r_hold  <= w_hold_nxt;
        end
        S_REPORT: begin
          r_last  <= r_owner;
          r_nack  <= 1'b0;
          r_rd_ok <= 1'b0;
        end
        default: begin
          r_nack  <= 1'b0;
          r_rd_ok <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Testbench for i2c_arbiter: directed steps plus randomized transactions,
// checked against a behavioural model of round-robin order, read data and
// error reporting. The I2C master is emulated inline by the stimulus tasks.
module tb_i2c_arbiter;
  localparam int N   = 4;
  localparam int TMO = 64;
  localparam int MODE_ACK      = 0;
  localparam int MODE_NACK     = 1;
  localparam int MODE_HANG     = 2;
  localparam int MODE_TMO_FALL = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [7*N-1:0] req_addr;
  logic [N-1:0]   req_rw;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0]   gnt, done, err;
  logic [7:0]     rdata;
  logic           m_start;
  logic [6:0]     m_addr;
  logic           m_rw;
  logic [7:0]     m_data_w;
  logic           m_busy;
  logic [7:0]     m_data_out;
  logic           m_valid_out;
  logic           m_erro_addr;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // reference model state
  int         mdl_last;
  logic [7:0] mdl_rdata;

  i2c_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_data_w(m_data_w),
    .m_busy(m_busy), .m_data_out(m_data_out), .m_valid_out(m_valid_out),
    .m_erro_addr(m_erro_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requesting index after the last one served.
  function automatic int mdl_winner(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic set_payload(input int i, input logic [6:0] a, input logic rw, input logic [7:0] d);
    req_addr[7*i +: 7]  = a;
    req_rw[i]           = rw;
    req_wdata[8*i +: 8] = d;
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // One full transaction: grant check, master emulation, completion check.
  task automatic run_txn(input int mode, input int b_len, input int v_pos,
                         input logic [7:0] rbyte, input bit drop_after_gnt);
    int         owner;
    logic [6:0] ea;
    logic       ew;
    logic [7:0] ed;
    bit         seen;
    owner = mdl_winner(req, mdl_last);
    if (owner < 0) owner = 0;
    ea = req_addr[7*owner +: 7];
    ew = req_rw[owner];
    ed = req_wdata[8*owner +: 8];
    wait_start(seen);
    chk("start_seen", 32'(seen), 32'(1));
    if (!seen) return;
    chk("gnt", 32'(gnt), 32'(1) << owner);
    chk("m_addr", 32'(m_addr), 32'(ea));
    chk("m_rw", 32'(m_rw), 32'(ew));
    chk("m_data_w", 32'(m_data_w), 32'(ed));
    // payload is free to change once granted
    if (drop_after_gnt) req[owner] = 1'b0;
    set_payload(owner, 7'($urandom), 1'($urandom), 8'($urandom));
    if (mode == MODE_ACK || mode == MODE_NACK) begin
      for (int p = 1; p <= b_len + 1; p++) begin
        m_busy      = (p <= b_len);
        m_valid_out = ew && (mode == MODE_ACK) && (p == v_pos);
        m_data_out  = (p == v_pos) ? rbyte : 8'($urandom);
        m_erro_addr = (mode == MODE_NACK) && (p == v_pos);
        @(negedge clk);
        if (p == 1) chk("start_pulse", 32'({m_start, gnt}), 32'(0));
        if (p == b_len) chk("done_early", 32'(done), 32'(0));
      end
    end else begin
      for (int p = 1; p <= TMO + 1; p++) begin
        m_busy      = !((mode == MODE_TMO_FALL) && (p == TMO + 1));
        m_valid_out = 1'b0;
        m_erro_addr = 1'b0;
        m_data_out  = 8'($urandom);
        @(negedge clk);
        if (p == TMO) chk("done_before_tmo", 32'(done), 32'(0));
      end
    end
    m_valid_out = 1'b0;
    m_erro_addr = 1'b0;
    if (mode == MODE_ACK && ew) mdl_rdata = rbyte;
    chk("done", 32'(done), 32'(1) << owner);
    chk("err", 32'(err), (mode != MODE_ACK) ? (32'(1) << owner) : 32'(0));
    chk("rdata", 32'(rdata), 32'(mdl_rdata));
    chk("m_addr_held", 32'(m_addr), 32'(ea));
    mdl_last = owner;
    @(negedge clk);
    chk("done_pulse", 32'({done, err}), 32'(0));
  endtask

  initial begin
    int  b;
    bit  seen;
    rst = 1'b1; req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
    m_busy = 1'b0; m_data_out = 8'h00; m_valid_out = 1'b0; m_erro_addr = 1'b0;
    mdl_last = N - 1; mdl_rdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_done_err", 32'({done, err}), 32'(0));
    chk("rst_start", 32'(m_start), 32'(0));
    chk("rst_cmd", 32'({m_addr, m_rw, m_data_w}), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // write to 0x50
    set_payload(0, 7'h50, 1'b0, 8'hA5);
    req = 4'b0001;
    run_txn(MODE_ACK, 3, 3, 8'h00, 1'b1);

    // read from 0x1D returning 0x3C
    set_payload(2, 7'h1D, 1'b1, 8'h77);
    req = 4'b0100;
    run_txn(MODE_ACK, 4, 4, 8'h3C, 1'b1);

    // address NACK on a read, coincident with busy fall
    set_payload(1, 7'h2A, 1'b1, 8'h00);
    req = 4'b0010;
    run_txn(MODE_NACK, 3, 4, 8'hEE, 1'b1);

    // all requesting, then drop requester 1
    for (int i = 0; i < N; i++) set_payload(i, 7'($urandom), 1'($urandom), 8'($urandom));
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      b = $urandom_range(2, 5);
      run_txn(MODE_ACK, b, $urandom_range(3, b + 1), 8'($urandom), 1'b0);
    end
    req[1] = 1'b0;
    for (int t = 0; t < 4; t++) begin
      b = $urandom_range(2, 5);
      run_txn(MODE_ACK, b, $urandom_range(3, b + 1), 8'($urandom), 1'b0);
    end

    // hung bus: watchdog fires, next grant waits for busy release
    set_payload(3, 7'h33, 1'b0, 8'h99);
    req = 4'b1000;
    run_txn(MODE_HANG, 2, 3, 8'h00, 1'b1);
    set_payload(0, 7'h11, 1'b1, 8'h00);
    req = 4'b0001;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("busy_blocks_grant", 32'({gnt, m_start}), 32'(0));
    end
    m_busy = 1'b0;
    run_txn(MODE_ACK, 3, 3, 8'h5C, 1'b1);

    // watchdog expiry on the same cycle busy falls
    set_payload(2, 7'h44, 1'b1, 8'h00);
    req = 4'b0100;
    run_txn(MODE_TMO_FALL, 2, 3, 8'h00, 1'b1);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) set_payload(i, 7'($urandom), 1'($urandom), 8'($urandom));
      req = 4'($urandom_range(1, 15));
      b = $urandom_range(2, 6);
      run_txn($urandom_range(0, 1), b, $urandom_range(3, b + 1), 8'($urandom), 1'($urandom));
    end

    // reset during WAIT_DONE
    set_payload(3, 7'h6B, 1'b0, 8'h5A);
    req = 4'b1000;
    wait_start(seen);
    chk("mid_start_seen", 32'(seen), 32'(1));
    req = 4'b0000;
    m_busy = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_m_addr", 32'(m_addr), 32'(7'h6B));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_pulses", 32'({gnt, done, err, m_start}), 32'(0));
    chk("mid_rst_cmd", 32'({m_addr, m_rw, m_data_w}), 32'(0));
    chk("mid_rst_rdata", 32'(rdata), 32'(0));
    mdl_last = N - 1;
    mdl_rdata = 8'h00;
    m_busy = 1'b0;
    set_payload(1, 7'h21, 1'b1, 8'h00);
    set_payload(3, 7'h63, 1'b0, 8'hC3);
    req = 4'b1010;
    @(negedge clk);
    rst = 1'b0;
    run_txn(MODE_ACK, 3, 4, 8'hB7, 1'b1);
    run_txn(MODE_ACK, 2, 3, 8'h00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
